// File: rtl/scurve_multi_trigger_test.sv
// S-curve trigger efficiency counter: counts CLK_EXT pulses and per-trigger responses, then dumps all counts to the FIFO.
// Latency: edge-to-count 3 Clk cycles; SCURVE_HEADER_EN adds a leading header word {8'hA5, 4'd0, N_TRIG}.
// Backpressure: while Data_fifo_full is high no word is written and SCurve_Data holds the pending word.
module scurve_multi_trigger_test #(
  parameter int N_TRIG     = 3,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 64
) (
  input  logic              Clk,
  input  logic              reset_n,
  input  logic              CLK_EXT,
  input  logic [N_TRIG-1:0] Trigger_b,
  input  logic              Test_Start,
  input  logic [CNT_W-1:0]  CPT_MAX,
  input  logic              Data_fifo_full,
  output logic [15:0]       SCurve_Data,
  output logic              SCurve_Data_wr_en,
  output logic              One_Channel_Done,
  output logic              Test_Busy
);

`ifdef SCURVE_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int NW = 2 * N_TRIG + HDR;
  localparam int IW = 5;
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [15:0] HDR_WORD = {8'hA5, 4'd0, 4'(N_TRIG)};

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_COUNT, S_SETTLE, S_OUTPUT, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [2:0]        ext_sync;
  logic [N_TRIG-1:0] trg_s0, trg_s1, trg_s2;
  logic              ts_q;
  logic              pulse_rise, start_rise, pulse_inc;
  logic [N_TRIG-1:0] trig_fall, trig_inc;

  logic [CNT_W-1:0]  max_q;
  logic [CNT_W-1:0]  pulse_cnt;
  logic [CNT_W-1:0]  trig_cnt [N_TRIG];
  logic [N_TRIG-1:0] hit;
  logic [SW-1:0]     settle_cnt;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     j;

  // Two sync flops followed by one edge-history flop per asynchronous input
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      ext_sync <= '0;
      trg_s0   <= '0;
      trg_s1   <= '0;
      trg_s2   <= '0;
      ts_q     <= 1'b0;
    end else begin
      ext_sync <= {ext_sync[1:0], CLK_EXT};
      trg_s0   <= Trigger_b;
      trg_s1   <= trg_s0;
      trg_s2   <= trg_s1;
      ts_q     <= Test_Start;
    end
  end

  assign pulse_rise = ext_sync[1] & ~ext_sync[2];
  assign trig_fall  = trg_s2 & ~trg_s1;
  assign start_rise = Test_Start & ~ts_q;

  assign pulse_inc = (state_q == S_COUNT) && pulse_rise && (pulse_cnt != max_q);

  // A pulse in the same cycle clears the hit flag first, so the trigger counts against the new pulse
  always_comb begin
    trig_inc = '0;
    for (int k = 0; k < N_TRIG; k++) begin
      trig_inc[k] = ((state_q == S_COUNT) || (state_q == S_SETTLE)) && trig_fall[k] &&
                    (pulse_inc || ((pulse_cnt != '0) && !hit[k]));
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    SCurve_Data_wr_en = 1'b0;
    One_Channel_Done  = 1'b0;
    Test_Busy         = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE:   if (start_rise) state_d = S_ARM;
      S_ARM: begin
        if (!Test_Start)          state_d = S_IDLE;
        else if (CPT_MAX == '0)   state_d = S_OUTPUT;
        else                      state_d = S_COUNT;
      end
      S_COUNT: begin
        if (!Test_Start)             state_d = S_IDLE;
        else if (pulse_cnt == max_q) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (!Test_Start)                            state_d = S_IDLE;
        else if (settle_cnt == SW'(SETTLE_CYC - 1)) state_d = S_OUTPUT;
      end
      S_OUTPUT: begin
        SCurve_Data_wr_en = !Data_fifo_full;
        if (!Data_fifo_full && (idx == IW'(NW - 1))) state_d = S_DONE;
      end
      S_DONE: begin
        One_Channel_Done = 1'b1;
        state_d          = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      max_q      <= '0;
      pulse_cnt  <= '0;
      hit        <= '0;
      settle_cnt <= '0;
      idx        <= '0;
      for (int k = 0; k < N_TRIG; k++) trig_cnt[k] <= '0;
    end else if (state_q == S_ARM) begin
      max_q      <= CPT_MAX;
      pulse_cnt  <= '0;
      hit        <= '0;
      settle_cnt <= '0;
      idx        <= '0;
      for (int k = 0; k < N_TRIG; k++) trig_cnt[k] <= '0;
    end else begin
      if (pulse_inc) pulse_cnt <= pulse_cnt + 1'b1;
      for (int k = 0; k < N_TRIG; k++) begin
        if (trig_inc[k]) begin
          hit[k]      <= 1'b1;
          trig_cnt[k] <= trig_cnt[k] + 1'b1;
        end else if (pulse_inc) begin
          hit[k] <= 1'b0;
        end
      end
      if (state_q == S_SETTLE) settle_cnt <= settle_cnt + 1'b1;
      if (SCurve_Data_wr_en)   idx <= idx + 1'b1;
    end
  end

  // Record layout after the optional header: pulse_cnt, trig_cnt[0], pulse_cnt, trig_cnt[1], ...
  always_comb begin
    SCurve_Data = '0;
    j           = idx - IW'(HDR);
    if (state_q == S_OUTPUT) begin
      if (!j[0]) begin
        SCurve_Data = 16'(pulse_cnt);
      end else begin
        for (int k = 0; k < N_TRIG; k++) begin
          if (j[IW-1:1] == (IW-1)'(k)) SCurve_Data = 16'(trig_cnt[k]);
        end
      end
`ifdef SCURVE_HEADER_EN
      if (idx == '0) SCurve_Data = HDR_WORD;
`endif
    end
  end

endmodule

// File: tb/tb_scurve_multi_trigger_test.sv
// Directed table-driven bench for scurve_multi_trigger_test (N_TRIG=3, CNT_W=16, SETTLE_CYC=64).
module tb_scurve_multi_trigger_test;

  localparam int N = 3;

  logic          Clk = 1'b0;
  logic          reset_n;
  logic          CLK_EXT;
  logic [N-1:0]  Trigger_b;
  logic          Test_Start;
  logic [15:0]   CPT_MAX;
  logic          Data_fifo_full;
  logic [15:0]   SCurve_Data;
  logic          SCurve_Data_wr_en;
  logic          One_Channel_Done;
  logic          Test_Busy;

  scurve_multi_trigger_test #(.N_TRIG(N), .CNT_W(16), .SETTLE_CYC(64)) dut (
    .Clk               (Clk),
    .reset_n           (reset_n),
    .CLK_EXT           (CLK_EXT),
    .Trigger_b         (Trigger_b),
    .Test_Start        (Test_Start),
    .CPT_MAX           (CPT_MAX),
    .Data_fifo_full    (Data_fifo_full),
    .SCurve_Data       (SCurve_Data),
    .SCurve_Data_wr_en (SCurve_Data_wr_en),
    .One_Channel_Done  (One_Channel_Done),
    .Test_Busy         (Test_Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int               cpt;
    int               np;
    int               m0, m1, m2;
    int               tog;
    bit               pre;
    logic [5:0][15:0] e;
  } vec_t;

  vec_t        vecs [6];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q [$];

  // Write monitor, sampled mid-cycle
  int          cyc = 0;
  logic [15:0] words [$];
  int          done_cnt = 0;
  int          last_wr_cyc = 0;
  int          done_cyc = 0;
  int          full_viol = 0;

  always @(negedge Clk) begin
    cyc++;
    if (SCurve_Data_wr_en) begin
      words.push_back(SCurve_Data);
      last_wr_cyc = cyc;
      if (Data_fifo_full) full_viol++;
    end
    if (One_Channel_Done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic vec_t mkv(int cpt, int np, int m0, int m1, int m2, int tog, bit pre,
                               int e0, int e1, int e2, int e3, int e4, int e5);
    vec_t v;
    v.cpt = cpt; v.np = np; v.m0 = m0; v.m1 = m1; v.m2 = m2; v.tog = tog; v.pre = pre;
    v.e[0] = 16'(e0); v.e[1] = 16'(e1); v.e[2] = 16'(e2);
    v.e[3] = 16'(e3); v.e[4] = 16'(e4); v.e[5] = 16'(e5);
    return v;
  endfunction

  function automatic void set_exp(logic [5:0][15:0] e);
    exp_q.delete();
`ifdef SCURVE_HEADER_EN
    exp_q.push_back(16'hA503);
`endif
    for (int i = 0; i < 6; i++) exp_q.push_back(e[i]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic start_test(input int cpt);
    CPT_MAX    = 16'(cpt);
    Test_Start = 1'b0;
    step(2);
    Test_Start = 1'b1;
    step(4);
  endtask

  task automatic pulse(input logic [N-1:0] fire, input int tog);
    CLK_EXT = 1'b1;
    step(2);
    for (int t = 0; t < tog; t++) begin
      Trigger_b = ~fire;
      step(2);
      Trigger_b = '1;
      step(2);
    end
    CLK_EXT = 1'b0;
    step(3);
  endtask

  task automatic wait_done(input int dbase);
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt > dbase) break;
      step(1);
    end
    step(2);
  endtask

  task automatic check_record(input string tag, input int wbase, input int dbase);
    chk({tag, "_nwords"}, words.size() - wbase, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (wbase + i < words.size())
        chk($sformatf("%s_w%0d", tag, i), int'(words[wbase + i]), int'(exp_q[i]));
    end
    chk({tag, "_done_cnt"}, done_cnt - dbase, 1);
    chk({tag, "_done_lag"}, done_cyc - last_wr_cyc, 1);
  endtask

  task automatic run_vec(input int vi);
    int wbase, dbase;
    vec_t v;
    v = vecs[vi];
    wbase = words.size();
    dbase = done_cnt;
    set_exp(v.e);
    start_test(v.cpt);
    if (v.pre) begin
      Trigger_b[0] = 1'b0;
      step(2);
      Trigger_b[0] = 1'b1;
      step(4);
    end
    for (int p = 0; p < v.np; p++)
      pulse({v.m2[p], v.m1[p], v.m0[p]}, v.tog);
    wait_done(dbase);
    check_record($sformatf("vec%0d", vi), wbase, dbase);
    Test_Start = 1'b0;
  endtask

  initial begin
    int wbase, dbase, bad_wr, bad_dat;

    vecs[0] = mkv(10, 10, 'h3FF, 'h00F, 'h000, 1, 0, 10, 10, 10, 4, 10, 0);
    vecs[1] = mkv( 5,  5, 'h001, 'h01F, 'h004, 3, 1,  5,  1,  5, 5,  5, 1);
    vecs[2] = mkv( 3,  3, 'h000, 'h004, 'h003, 1, 0,  3,  0,  3, 1,  3, 2);
    vecs[3] = mkv( 1,  1, 'h000, 'h000, 'h001, 1, 0,  1,  0,  1, 0,  1, 1);
    // Extra pulses land in SETTLE: hit[0] stays set, trigger 1 first fires there
    vecs[4] = mkv( 2,  4, 'h007, 'h008, 'h000, 1, 0,  2,  2,  2, 1,  2, 0);
    vecs[5] = mkv( 0,  0, 'h000, 'h000, 'h000, 1, 0,  0,  0,  0, 0,  0, 0);

    reset_n        = 1'b0;
    CLK_EXT        = 1'b0;
    Trigger_b      = '1;
    Test_Start     = 1'b0;
    CPT_MAX        = '0;
    Data_fifo_full = 1'b0;
    step(3);
    chk("rst_wr_en", SCurve_Data_wr_en, 0);
    chk("rst_data",  SCurve_Data, 0);
    chk("rst_done",  One_Channel_Done, 0);
    chk("rst_busy",  Test_Busy, 0);
    reset_n = 1'b1;
    step(3);
    chk("idle_busy", Test_Busy, 0);

    for (int vi = 0; vi < 6; vi++) run_vec(vi);

    // Abort after 3 of 10 pulses
    wbase = words.size();
    dbase = done_cnt;
    start_test(10);
    chk("busy_after_start", Test_Busy, 1);
    for (int p = 0; p < 3; p++) pulse(3'b011, 1);
    Test_Start = 1'b0;
    step(2);
    chk("abort_busy", Test_Busy, 0);
    step(100);
    chk("abort_words", words.size() - wbase, 0);
    chk("abort_done",  done_cnt - dbase, 0);
    wbase = words.size();
    dbase = done_cnt;
    set_exp({16'd0, 16'd2, 16'd0, 16'd2, 16'd2, 16'd2});
    start_test(2);
    pulse(3'b001, 1);
    pulse(3'b001, 1);
    wait_done(dbase);
    check_record("after_abort", wbase, dbase);
    Test_Start = 1'b0;

    // FIFO full across OUTPUT entry, then released with a toggling full flag
    wbase = words.size();
    dbase = done_cnt;
    set_exp({16'd0, 16'd3, 16'd0, 16'd3, 16'd3, 16'd3});
    Data_fifo_full = 1'b1;
    start_test(3);
    for (int p = 0; p < 3; p++) pulse(3'b001, 1);
    step(100);
    bad_wr  = 0;
    bad_dat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (SCurve_Data_wr_en) bad_wr++;
      if (SCurve_Data !== exp_q[0]) bad_dat++;
    end
    chk("stall_wr_en", bad_wr, 0);
    chk("stall_data",  bad_dat, 0);
    chk("stall_busy",  Test_Busy, 1);
    for (int i = 0; i < 200; i++) begin
      if (done_cnt > dbase) break;
      Data_fifo_full = ~Data_fifo_full;
      step(1);
    end
    Data_fifo_full = 1'b0;
    step(2);
    check_record("fifo_full", wbase, dbase);
    chk("wr_while_full", full_viol, 0);
    Test_Start = 1'b0;

    // Late triggers: 10 cycles after the last pulse counts, 80 cycles does not
    wbase = words.size();
    dbase = done_cnt;
    set_exp({16'd0, 16'd2, 16'd1, 16'd2, 16'd0, 16'd2});
    start_test(2);
    pulse(3'b000, 1);
    pulse(3'b000, 1);
    step(1);
    Trigger_b[1] = 1'b0;
    step(2);
    Trigger_b[1] = 1'b1;
    step(68);
    Trigger_b[2] = 1'b0;
    step(2);
    Trigger_b[2] = 1'b1;
    wait_done(dbase);
    check_record("settle", wbase, dbase);
    Test_Start = 1'b0;

    // Asynchronous reset in the middle of COUNT
    start_test(10);
    pulse(3'b111, 1);
    pulse(3'b111, 1);
    #3 reset_n = 1'b0;
    #1;
    chk("midrst_busy",  Test_Busy, 0);
    chk("midrst_wr_en", SCurve_Data_wr_en, 0);
    chk("midrst_data",  SCurve_Data, 0);
    chk("midrst_done",  One_Channel_Done, 0);
    Test_Start = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(3);
    chk("midrst_idle", Test_Busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scurve_multi_trigger_test.md
Name: scurve_multi_trigger_test

Overview:
- Parametrised successor of the 3-trigger single-channel S-curve test.
- Counts injected charge pulses (CLK_EXT rising edges) and the per-trigger responses of N_TRIG active-low ASIC trigger outputs.
- After CPT_MAX pulses plus a settle window, serialises all counts into the downstream S-curve FIFO, honouring its full flag.
- Sits between the channel/DAC sweep controller (Test_Start, One_Channel_Done) and the USB readout FIFO.

Parameters:
- N_TRIG, 3, number of trigger inputs; 1..8.
- CNT_W, 16, pulse/trigger counter width; 1..16, zero-extended to 16-bit output words.
- SETTLE_CYC, 64, Clk cycles after the last pulse during which late triggers are still counted; ≥1.

Ports:
- Clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- CLK_EXT  input  1  injection strobe, asynchronous to Clk; rising edge = one pulse.
- Trigger_b  input  N_TRIG  active-low trigger outputs, asynchronous.
- Test_Start  input  1  a rising edge starts a test; low during COUNT/SETTLE aborts it.
- CPT_MAX  input  CNT_W  pulses per test; sampled in ARM.
- Data_fifo_full  input  1  downstream FIFO full.
- SCurve_Data  output  16  data word.
- SCurve_Data_wr_en  output  1  write strobe; one word per asserted cycle.
- One_Channel_Done  output  1  one-cycle pulse after the last word is written.
- Test_Busy  output  1  high in every state except IDLE.

Behaviour:
- Clock and reset:
  - Single clock Clk; reset_n is asynchronous and active-low.
  - During reset all outputs are 0 and all counters, flags and synchronisers are cleared.
- Synchronisation:
  - CLK_EXT and each Trigger_b bit pass through a 2-flop synchroniser plus an edge detector.
  - Edge-to-count latency is 3 Clk cycles.
- State machine: IDLE, ARM, COUNT, SETTLE, OUTPUT, DONE.
  - IDLE: wait for a Test_Start rising edge (0→1 across consecutive Clk samples). A level held high does not restart a test.
  - ARM (1 cycle): clear all counters and hit flags; latch CPT_MAX into max_q.
    - If max_q == 0, go directly to OUTPUT with all counts 0.
    - Otherwise go to COUNT.
  - COUNT:
    - Each CLK_EXT rising edge increments pulse_cnt and clears all hit flags.
    - Trigger_b[k] falling edge, with pulse_cnt ≥ 1 and hit[k] == 0: increment trig_cnt[k] and set hit[k]. At most one trigger per pulse per input, so trig_cnt[k] ≤ pulse_cnt.
    - Trigger edges before the first pulse are ignored.
    - When pulse_cnt == max_q, go to SETTLE. Further CLK_EXT edges are ignored.
  - SETTLE: run SETTLE_CYC cycles. Trigger counting continues against the last pulse; hit flags are not cleared. Then go to OUTPUT.
  - OUTPUT: emit 2·N_TRIG words in the order pulse_cnt, trig_cnt[0], pulse_cnt, trig_cnt[1], … (pulse_cnt is repeated per trigger for legacy format compatibility).
    - SCurve_Data_wr_en = 1 only in cycles where Data_fifo_full == 0. The word index advances only on a write.
    - While Data_fifo_full is high, hold wr_en at 0 and keep SCurve_Data stable at the pending word.
    - Back-to-back writes are allowed, one per cycle.
  - DONE (1 cycle): assert One_Channel_Done, then go to IDLE.
- Abort: Test_Start low in ARM, COUNT or SETTLE returns to IDLE next cycle. No words are written and no Done pulse is issued. Test_Start is ignored once OUTPUT is entered.
- Simultaneous edges:
  - CLK_EXT edge and trigger edge detected in the same cycle: the pulse increments and the hit flags clear first, so that trigger counts for the new pulse.
  - A pulse edge arriving in the same cycle pulse_cnt reaches max_q is not counted.
- Mid-operation reset: immediate return to IDLE with all outputs 0. Any partially written record is the consumer's concern.
- Arithmetic: counters are CNT_W bits and cannot exceed max_q (at most 2^CNT_W−1), so no wrap occurs. Output words are zero-extended.

Optional Feature:
- Macro SCURVE_HEADER_EN.
- Defined: OUTPUT first emits a header word {8'hA5, 4'd0, N_TRIG[3:0]}, subject to the same full-flag rule, then the 2·N_TRIG data words; 2·N_TRIG+1 words total.
- Undefined: no header word; exactly 2·N_TRIG words.

Test Plan:
- N_TRIG=3, CPT_MAX=10, 10 CLK_EXT pulses, Trigger_b[0] fires once per pulse, [1] on pulses 1–4, [2] never → words 10,10,10,4,10,0; One_Channel_Done pulses once, one cycle after the 6th write.
- CPT_MAX=5, Trigger_b[0] toggles 3 times inside one pulse window → trig_cnt[0] = 1; trigger before the first pulse is not counted.
- Data_fifo_full held high for 20 cycles at OUTPUT entry, then released → no wr_en while full; SCurve_Data stable; all 6 words in order, no drop or duplicate.
- Test_Start dropped after 3 of 10 pulses → return to IDLE, zero writes, no Done. Subsequent rising edge with CPT_MAX=2 → correct fresh counts 2,…
- CPT_MAX=0 → 6 zero words, then Done. With SCURVE_HEADER_EN defined, A5 03 is first (7 words).
- Trigger falling edge 10 cycles after the last pulse (SETTLE_CYC=64) → counted; edge at 80 cycles → not counted.
